au_sign_norm_iter: RTL and testbench
====================================

Name: au_sign_norm_iter

Overview:
- Sequential sign normalizer for two's-complement words. It is the consumer of the leading-sign information the AU_lead_sign_det block produces.
- Each accepted word is left-shifted until its two MSBs differ, removing redundant sign bits. The block returns the normalized word and the shift count.
- Sits in front of FP/block-floating-point packers and AGC gain logic. Valid/ready streaming interface on both sides.

Parameters:
- WIDTH, 8, word length of a and z; legal range 2..64.
- CW, $clog2(WIDTH), width of the shift-count output. Derived localparam; not user-settable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  a is valid.
- in_ready  output  1  block can accept a.
- a  input  WIDTH  signed input word.
- out_valid  output  1  z, cnt and zero are valid.
- out_ready  input  1  downstream accepts the result.
- z  output  WIDTH  normalized word.
- cnt  output  CW  number of left shifts applied (0..WIDTH-1).
- zero  output  1  input word was all zeros.

Behaviour:
- Reset: one clock with rst_n=0 at the edge forces the following, regardless of current state, including mid-SHIFT:
  - state=IDLE, out_valid=0, z=0, cnt=0, zero=0.
  - in_ready=1 one cycle after reset is released.
  - Any in-flight word is discarded.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational from state and out_ready only; never from in_valid.
- Accept (in_valid & in_ready at an edge): load work=a, cnt=0, zero=(a==0); next state SHIFT. Fires back-to-back from DONE when out_ready=1.
- SHIFT, evaluated each edge:
  - if work[W-1]!=work[W-2] or cnt==WIDTH-1: go to DONE, no shift.
  - else: work<=work<<1 (zero fill), cnt<=cnt+1.
- Latency: accept at edge k with final shift s gives out_valid=1 after edge k+s+1.
- DONE:
  - out_valid=1; z=work.
  - z, cnt and zero are held stable while out_ready=0.
  - On out_ready=1 at an edge: go to IDLE, or straight to SHIFT if a new word is accepted in the same edge.
- Saturation cases:
  - a=0: z=0, cnt=WIDTH-1, zero=1.
  - a=all ones: z=1 followed by zeros (-2^(W-1)), cnt=WIDTH-1, zero=0.
- Invariant: z == a<<cnt, evaluated mod 2^WIDTH.
- Invariant: cnt == (number of leading sign bits of a) - 1, clamped to WIDTH-1.
- z and cnt are don't-care unless out_valid=1, but z and cnt must only change at accept or during SHIFT.
- in_valid without in_ready: input is ignored and not latched. The source must hold a until the handshake.

Optional Feature:
- Macro AU_SIGN_NORM_FAST_EN.
- Defined:
  - In SHIFT, if the top 3 bits of work are equal and cnt<=WIDTH-3: shift by 2 and cnt+=2.
  - Else the 1-bit rule applies.
  - Results are identical to the 1-bit mode. Latency becomes (number of steps)+1.
- Undefined: strictly 1 bit per cycle, as described above.
- The bench checks the result in both builds and checks latency per build.

Test Plan:
- Reset: assert rst_n=0 while in SHIFT with a=0x03 -> after the reset edge out_valid=0, z=0, cnt=0; in_ready=1 once rst_n=1.
- Normal case (WIDTH=8): a=0x03, out_ready=1 -> z=0x60, cnt=5, zero=0.
  - out_valid rises 6 edges after accept.
  - With FAST_EN: 4 edges (steps 2,2,1).
- Already normalized: a=0x40 -> z=0x40, cnt=0, latency 1. a=0xF0 -> z=0x80, cnt=3.
- Saturation: a=0x00 -> z=0x00, cnt=7, zero=1. a=0xFF -> z=0x80, cnt=7, zero=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> z/cnt stable and in_ready=0. Then assert out_ready with in_valid=1, a=0x1F -> same-edge accept; next result z=0x7C, cnt=2.
- Exhaustive: all 256 inputs with random out_ready/in_valid gaps -> every result matches the invariant, no lost or duplicated words.

Source files
------------

// File: rtl/au_sign_norm_iter.sv
// au_sign_norm_iter: iterative two's-complement sign normalizer with valid/ready on both sides.
// Define AU_SIGN_NORM_FAST_EN to shift two bits per step when three sign bits remain.
module au_sign_norm_iter #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] z_o,
  output logic [CW-1:0]    cnt_o,
  output logic             zero_o
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic zero_q, zero_d;
  logic accept, stop, fast;
  assign in_ready_o = (state_q == IDLE) || (state_q == DONE && out_ready_i);
  assign accept = in_valid_i && in_ready_o;
  assign stop = (work_q[WIDTH-1] != work_q[WIDTH-2]) || (cnt_q == CW'(WIDTH-1));
  assign out_valid_o = state_q == DONE;
  assign z_o = work_q;
  assign cnt_o = cnt_q;
  assign zero_o = zero_q;
`ifdef AU_SIGN_NORM_FAST_EN
  // a double step is only safe while it cannot overshoot the clamp at WIDTH-1
  if (WIDTH >= 3) begin : g_fast
    assign fast = (work_q[WIDTH-1] == work_q[WIDTH-2]) && (work_q[WIDTH-2] == work_q[WIDTH-3])
                  && (int'(cnt_q) <= WIDTH-3);
  end else begin : g_nofast
    assign fast = 1'b0;
  end
`else
  assign fast = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    work_d = work_q;
    cnt_d = cnt_q;
    zero_d = zero_q;
    if (accept) begin
      state_d = SHIFT;
      work_d = a_i;
      cnt_d = '0;
      zero_d = a_i == '0;
    end else if (state_q == SHIFT) begin
      state_d = stop ? DONE : SHIFT;
      work_d = stop ? work_q : fast ? work_q << 2 : work_q << 1;
      cnt_d = stop ? cnt_q : cnt_q + (fast ? CW'(2) : CW'(1));
    end else if (state_q == DONE && out_ready_i) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q <= '0;
      cnt_q <= '0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q <= work_d;
      cnt_q <= cnt_d;
      zero_q <= zero_d;
    end
  end
endmodule

// File: tb/tb_au_sign_norm_iter.sv
// tb_au_sign_norm_iter: scoreboard bench for au_sign_norm_iter (WIDTH=8), result and latency checks.
module tb_au_sign_norm_iter;
`ifdef AU_SIGN_NORM_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 0, rst_n, in_valid, in_ready, out_valid, out_ready, zero;
  logic [7:0] a, z;
  logic [2:0] cnt;
  int n_cmp = 0, n_err = 0, cyc = 0, lat_meas = 0;
  bit rand_en = 0, ov_prev = 0;
  typedef struct { logic [7:0] z; logic [2:0] c; logic zr; int lat; int acc; } exp_t;
  exp_t exp_q[$];
  exp_t e;

  au_sign_norm_iter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready), .a_i(a),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .z_o(z), .cnt_o(cnt), .zero_o(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_en) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] v, input logic [7:0] ez, input logic [2:0] ec,
                      input logic ezr, input int elat);
    bit done = 0;
    exp_t x;
    in_valid = 1;
    a = v;
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        x.z = ez; x.c = ec; x.zr = ezr; x.lat = elat; x.acc = cyc + 1;
        exp_q.push_back(x);
        done = 1;
      end
      tick();
    end
    in_valid = 0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && exp_q.size() > 0; t++) tick();
    chk("pending_results", exp_q.size(), 0);
  endtask

  function automatic void model(input logic [7:0] v, output logic [7:0] mz, output logic [2:0] mc,
                                output int mlat);
    int n = 1, k = 0, s = 0;
    bit run = 1;
    for (int i = 6; i >= 0; i--) begin
      if (run && v[i] == v[7]) n++;
      else run = 0;
    end
    mc = 3'(n - 1);
    mz = v << (n - 1);
    if (FAST) begin
      while (k < n - 1) begin
        k += (n - 1 - k >= 2 && k <= 5) ? 2 : 1;
        s++;
      end
      mlat = s + 1;
    end else mlat = n;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) ov_prev = 0;
    else begin
      if (out_valid && !ov_prev) begin
        if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
        else lat_meas = cyc - exp_q[0].acc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("duplicate_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("z", z, e.z);
          chk("cnt", cnt, e.c);
          chk("zero", zero, e.zr);
          chk("latency", lat_meas, e.lat);
        end
      end
      ov_prev = out_valid;
    end
  end

  initial begin
    logic [7:0] mz;
    logic [2:0] mc;
    int ml;
    rst_n = 0; in_valid = 0; a = 0; out_ready = 0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_z", z, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_zero", zero, 0);
    rst_n = 1;
    tick();
    chk("rst_in_ready", in_ready, 1);
    // reset while the word is still shifting
    out_ready = 1;
    send(8'h03, 8'h60, 3'd5, 0, FAST ? 4 : 6);
    tick();
    rst_n = 0;
    tick();
    exp_q.delete();
    chk("midshift_rst_out_valid", out_valid, 0);
    chk("midshift_rst_z", z, 0);
    chk("midshift_rst_cnt", cnt, 0);
    chk("midshift_rst_zero", zero, 0);
    rst_n = 1;
    tick();
    chk("midshift_in_ready", in_ready, 1);
    send(8'h03, 8'h60, 3'd5, 0, FAST ? 4 : 6); drain();
    send(8'h40, 8'h40, 3'd0, 0, 1);            drain();
    send(8'hF0, 8'h80, 3'd3, 0, FAST ? 3 : 4); drain();
    send(8'h00, 8'h00, 3'd7, 1, FAST ? 5 : 8); drain();
    send(8'hFF, 8'h80, 3'd7, 0, FAST ? 5 : 8); drain();
    // backpressure, then same-edge release and accept
    out_ready = 0;
    send(8'h20, 8'h40, 3'd1, 0, 2);
    for (int t = 0; t < 50 && !out_valid; t++) tick();
    chk("bp_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_z_hold", z, 8'h40);
      chk("bp_cnt_hold", cnt, 1);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    send(8'h1F, 8'h7C, 3'd2, 0, FAST ? 2 : 3);
    drain();
    // every input, random gaps on both sides
    rand_en = 1;
    for (int v = 0; v < 256; v++) begin
      model(8'(v), mz, mc, ml);
      send(8'(v), mz, mc, v == 0, ml);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
    drain();
    rand_en = 0;
    out_ready = 1;
    tick();
    chk("idle_after_all", out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
